// File: rtl/ebox_pkg.sv
// ebox_pkg: shared EBOX types and constants for the shift sequencer.
package ebox_pkg;
    typedef enum logic [1:0] {LSHC = 2'b00, ROTC = 2'b01, ASHC = 2'b10} shop_t;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} shseq_state_t;
    localparam int SHSEQ_STEP_MAX = 35;
endpackage

// File: rtl/shseq_shstep.sv
// shstep: one combinational shift step of the 72-bit AR!ARX pair.
module shstep
    import ebox_pkg::*;
(
    input  logic [71:0] w,
    input  logic [5:0]  step,
    input  logic        dir,
    input  shop_t       op,
    input  logic        s,
    output logic [71:0] w_nxt,
    output logic        ovf
);
    logic [69:0]  m, m_r, fill, keep;
    logic [139:0] ml_ext;
    logic [71:0]  rot_l, rot_r;
    always_comb begin
        rot_l  = (w << step) | (w >> (7'd72 - {1'b0, step}));
        rot_r  = (w >> step) | (w << (7'd72 - {1'b0, step}));
        // ASHC works on the 70-bit magnitude; bits 71 and 35 are sign slots
        m      = {w[70:36], w[34:0]};
        ml_ext = {70'd0, m} << step;
        fill   = ~({70{1'b1}} >> step) & {70{s}};
        m_r    = (m >> step) | fill;
        keep   = ~({70{1'b1}} << step);
        w_nxt  = (op == ROTC) ? (dir ? rot_r : rot_l) :
                 (op == ASHC) ? (dir ? {s, m_r[69:35], s, m_r[34:0]}
                                     : {s, ml_ext[69:35], s, ml_ext[34:0]}) :
                 (dir ? (w >> step) : (w << step));
        ovf    = (op == ASHC) && !dir && |((ml_ext[139:70] ^ {70{s}}) & keep);
    end
endmodule

// File: rtl/shseq.sv
// shseq: multi-cycle LSHC/ROTC/ASHC sequencer for the AR!ARX pair,
// consuming the signed count in steps of at most STEP_MAX positions.
module shseq
    import ebox_pkg::*;
#(
    parameter int STEP_MAX = SHSEQ_STEP_MAX
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [8:0]  count,
    input  logic [35:0] ar_in,
    input  logic [35:0] arx_in,
    output logic [35:0] ar_out,
    output logic [35:0] arx_out,
    output logic        busy,
    output logic        done,
    output logic        ovf
);
    shseq_state_t state_q, state_d;
    shop_t        op_q, op_d;
    logic         dir_q, dir_d, s_q, s_d, ovf_q, ovf_d;
    logic [8:0]   rem_q, rem_d, mag;
    logic [71:0]  w_q, w_d, w_nxt;
    logic [5:0]   step;
    logic         last, accept, step_ovf;

    shstep u_shstep (
        .w     (w_q),
        .step  (step),
        .dir   (dir_q),
        .op    (op_q),
        .s     (s_q),
        .w_nxt (w_nxt),
        .ovf   (step_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= LSHC;
            dir_q   <= 1'b0;
            s_q     <= 1'b0;
            ovf_q   <= 1'b0;
            rem_q   <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dir_q   <= dir_d;
            s_q     <= s_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
            w_q     <= w_d;
        end
    end

    always_comb begin
        last    = rem_q <= 9'(STEP_MAX);
        state_d = (state_q == IDLE)  ? (start ? SHIFT : IDLE) :
                  (state_q == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
    end

    always_comb begin
        accept = (state_q == IDLE) && start;
        step   = last ? rem_q[5:0] : 6'(STEP_MAX);
        // -256 negates to itself, which as an unsigned 9-bit value is 256
        mag    = count[8] ? 9'(-count) : count;
        op_d   = accept ? ((op == 2'b11) ? LSHC : shop_t'(op)) : op_q;
        dir_d  = accept ? count[8] : dir_q;
        s_d    = accept ? ar_in[35] : s_q;
        w_d    = accept ? {ar_in, arx_in} : (state_q == SHIFT) ? w_nxt : w_q;
        rem_d  = accept ? mag : (state_q == SHIFT) ? rem_q - {3'd0, step} : rem_q;
        ovf_d  = accept ? 1'b0 : (state_q == SHIFT) ? (ovf_q | step_ovf) : ovf_q;
    end

    always_comb begin
        busy    = state_q != IDLE;
        done    = state_q == DONE;
        ovf     = ovf_q;
        ar_out  = w_q[71:36];
        arx_out = w_q[35:0];
    end
endmodule

// File: tb/tb_shseq.sv
// tb_shseq: directed scoreboard bench for shseq; the driver queues expected
// results and a negedge monitor checks them whenever done pulses.
module tb_shseq;
    logic        clk = 1'b0, reset, start;
    logic [1:0]  op;
    logic [8:0]  count;
    logic [35:0] ar_in, arx_in, ar_out, arx_out;
    logic        busy, done, ovf;
    int          tests = 0, fails = 0, cyc = 0;

    typedef struct {
        string       name;
        logic [35:0] ar, arx;
        logic        ovf;
        int          acc, lat;
    } exp_t;
    exp_t q[$];

    shseq dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .count   (count),
        .ar_in   (ar_in),
        .arx_in  (arx_in),
        .ar_out  (ar_out),
        .arx_out (arx_out),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %o expected %o", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            exp_t e;
            check("busy_with_done", 64'(busy), 64'd1);
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: ar=%o arx=%o", ar_out, arx_out);
            end else begin
                e = q.pop_front();
                check({e.name, "_ar"}, 64'(ar_out), 64'(e.ar));
                check({e.name, "_arx"}, 64'(arx_out), 64'(e.arx));
                check({e.name, "_ovf"}, 64'(ovf), 64'(e.ovf));
                check({e.name, "_lat"}, 64'(cyc - e.acc + 1), 64'(e.lat));
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d results outstanding", q.size());
            q.delete();
        end
    endtask

    task automatic run(input string nm, input logic [1:0] o, input logic [8:0] c,
                       input logic [35:0] a, input logic [35:0] x,
                       input logic [35:0] ea, input logic [35:0] ex,
                       input logic eo, input int lat);
        @(negedge clk);
        op = o; count = c; ar_in = a; arx_in = x; start = 1'b1;
        q.push_back('{nm, ea, ex, eo, cyc + 1, lat});
        @(negedge clk);
        start = 1'b0;
        drain();
    endtask

    initial begin
        int a;
        reset = 1'b1; start = 1'b0; op = 2'b00; count = '0; ar_in = '0; arx_in = '0;
        repeat (2) @(negedge clk);
        check("rst_ar", 64'(ar_out), 64'd0);
        check("rst_arx", 64'(arx_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        reset = 1'b0;

        run("lshc_p40",  2'b00, 9'd40,   36'o0, 36'o1, 36'o000000000020, 36'o0, 1'b0, 3);
        run("lshc_m36",  2'b00, -9'sd36, 36'o123, 36'o7, 36'o0, 36'o123, 1'b0, 3);
        run("lshc_zero", 2'b00, 9'd0,    36'o123456701234, 36'o765432107654,
            36'o123456701234, 36'o765432107654, 1'b0, 2);
        run("lshc_m256", 2'b00, 9'h100,  36'o777777777777, 36'o777777777777, 36'o0, 36'o0, 1'b0, 9);
        run("rsvd_p4",   2'b11, 9'd4,    36'o0, 36'o1, 36'o0, 36'o20, 1'b0, 2);
        run("rotc_m1",   2'b01, -9'sd1,  36'o400000000000, 36'o0, 36'o200000000000, 36'o0, 1'b0, 2);
        run("rotc_p72",  2'b01, 9'd72,   36'o400000000000, 36'o0, 36'o400000000000, 36'o0, 1'b0, 4);
        run("rotc_p1",   2'b01, 9'd1,    36'o400000000000, 36'o0, 36'o0, 36'o1, 1'b0, 2);
        run("rotc_m256", 2'b01, 9'h100,  36'o0, 36'o1, 36'o0, 36'o040000000000, 1'b0, 9);
        run("ashc_m100", 2'b10, -9'sd100, 36'o777777777777, 36'o777777777777,
            36'o777777777777, 36'o777777777777, 1'b0, 4);
        run("ashc_p35",  2'b10, 9'd35,   36'o1, 36'o0, 36'o0, 36'o0, 1'b1, 2);
        run("ashc_p3",   2'b10, 9'd3,    36'o0, 36'o1, 36'o0, 36'o10, 1'b0, 2);
        run("ashc_m1",   2'b10, -9'sd1,  36'o400000000000, 36'o400000000000,
            36'o600000000000, 36'o400000000000, 1'b0, 2);
        run("ashc_p1",   2'b10, 9'd1,    36'o377777777777, 36'o0, 36'o377777777776, 36'o0, 1'b1, 2);

        // abort a long shift with reset during its second SHIFT cycle
        @(negedge clk);
        op = 2'b00; count = 9'd200; ar_in = 36'o777777777777; arx_in = 36'o777777777777; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_ar", 64'(ar_out), 64'd0);
        check("abort_arx", 64'(arx_out), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        run("post_rst", 2'b00, 9'd1, 36'o0, 36'o400000000000, 36'o1, 36'o0, 1'b0, 2);

        // start held high: accepts only in IDLE, one every 4 cycles
        @(negedge clk);
        op = 2'b00; count = 9'd36; ar_in = 36'o0; arx_in = 36'o1; start = 1'b1;
        a = cyc + 1;
        for (int i = 0; i < 3; i++) q.push_back('{"b2b", 36'o1, 36'o0, 1'b0, a + 4 * i, 3});
        repeat (9) @(negedge clk);
        start = 1'b0;
        drain();
        repeat (6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
